// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronizes/filters the raw lines, frames 11-bit packets, folds E0/F0
// prefixes into the ps2_key event word. Define PS2_PAUSE_COLLAPSE_EN to collapse the E1 Pause sequence.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nx;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            clk_f, clk_f_q;
    logic [7:0]      filt_cnt;
    logic            fall;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            par_ok;
    logic [TW-1:0]   tcnt;
    logic            timeout;
    logic            byte_valid;
    logic            ext, rel;
`ifdef PS2_PAUSE_COLLAPSE_EN
    logic [2:0]      skip;
`endif

    // Synchronizers and clock filter; all idle-high so reset never produces a false fall.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_f    <= 1'b1;
            clk_f_q  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            dat_s1  <= ps2_data;
            dat_s2  <= dat_s1;
            clk_f_q <= clk_f;
            if (clk_s2 != clk_f) begin
                if (filt_cnt == 8'(FILTER_LEN - 1)) begin
                    clk_f    <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 8'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall    = clk_f_q & ~clk_f;
    // A fall in the same cycle as expiry keeps the frame alive.
    assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (timeout) begin
            state_nx = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!dat_s2) state_nx = DATA;
                DATA:    if (bitcnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bitcnt     <= '0;
            shreg      <= '0;
            par_ok     <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall || state == IDLE) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;
            if (timeout) begin
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE:   bitcnt <= '0;
                    DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY: par_ok <= ^{shreg, dat_s2};
                    STOP: begin
                        if (dat_s2 && par_ok) byte_valid <= 1'b1;
                        else                  frame_err  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte decode: prefixes latch flags, real codes emit an event and clear them.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ps2_key <= '0;
            ext     <= 1'b0;
            rel     <= 1'b0;
`ifdef PS2_PAUSE_COLLAPSE_EN
            skip    <= '0;
`endif
        end else if (frame_err) begin
            ext <= 1'b0;
            rel <= 1'b0;
`ifdef PS2_PAUSE_COLLAPSE_EN
            skip <= '0;
`endif
        end else if (byte_valid) begin
`ifdef PS2_PAUSE_COLLAPSE_EN
            if (skip != 3'd0) begin
                skip <= skip - 3'd1;
                if (skip == 3'd1) ps2_key <= {~ps2_key[10], 1'b1, 1'b1, 8'h77};
            end else
`endif
            case (shreg)
                8'hE0: ext <= 1'b1;
                8'hF0: rel <= 1'b1;
                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
`ifdef PS2_PAUSE_COLLAPSE_EN
                8'hE1: skip <= 3'd7;
`else
                8'hE1: ;
`endif
                default: begin
                    ps2_key <= {~ps2_key[10], ~rel, ext, shreg};
                    ext     <= 1'b0;
                    rel     <= 1'b0;
                end
            endcase
        end
    end
endmodule
